// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB instruction controller: sizes, field widths,
// instruction encodings and the controller state encoding.
package tlb_pkg;

    localparam int ENTRIES = 16;
    localparam int IDXW    = 4;
    localparam int VPN2_W  = 19;
    localparam int MASK_W  = 16;
    localparam int ASID_W  = 8;

    localparam logic [1:0] OP_TLBR  = 2'b00;
    localparam logic [1:0] OP_TLBWI = 2'b01;
    localparam logic [1:0] OP_TLBWR = 2'b10;
    localparam logic [1:0] OP_TLBP  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_CAP  = 3'd2,
        ST_WR      = 3'd3,
        ST_PR_ADDR = 3'd4,
        ST_PR_CAP  = 3'd5
    } state_t;

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// Bundle of the instruction request/response, CP0 operands and both CAM ports
// seen by the TLB instruction controller.
//
// Handshake: a request is taken on a rising edge where Op_Valid && Op_Ready;
// every operand is captured on that edge. Op_Valid while Op_Ready is low is
// dropped, not queued. Op_Done pulses for one cycle when the instruction ends,
// and Op_Ready is already high in that same cycle so requests can run back to back.
interface tlb_op_ctrl_if;
    import tlb_pkg::*;

    // instruction request / response
    logic              Op_Valid;
    logic [1:0]        Op_Code;
    logic              Op_Ready;
    logic              Op_Done;

    // CP0 operands
    logic [IDXW-1:0]   CP0_Index;
    logic [IDXW-1:0]   CP0_Wired;
    logic              Wired_Write;
    logic [VPN2_W-1:0] EntryHi_VPN2;
    logic [ASID_W-1:0] EntryHi_ASID;
    logic [MASK_W-1:0] PageMask;
    logic              EntryLo_G;
    logic [IDXW-1:0]   Random;

    // CAM index port (read/write by index)
    logic [IDXW-1:0]   Idx_Index;
    logic              Idx_Write;
    logic [VPN2_W-1:0] Idx_VPN2;
    logic [MASK_W-1:0] Idx_Mask;
    logic [ASID_W-1:0] Idx_ASID;
    logic              Idx_G;
    logic [VPN2_W-1:0] Idx_VPN2_Out;
    logic [MASK_W-1:0] Idx_Mask_Out;
    logic [ASID_W-1:0] Idx_ASID_Out;
    logic              Idx_G_Out;

    // CAM lookup port B
    logic [VPN2_W:0]   VPN_B;
    logic [ASID_W-1:0] ASID_B;
    logic              Hit_B;
    logic [IDXW-1:0]   Index_B;

    // results
    logic [VPN2_W-1:0] Rd_VPN2;
    logic [MASK_W-1:0] Rd_Mask;
    logic [ASID_W-1:0] Rd_ASID;
    logic              Rd_G;
    logic              Probe_Miss;
    logic [IDXW-1:0]   Probe_Index;

    // controller state, for observation only
    state_t            dbg_state;

    modport slave (
        input  Op_Valid, Op_Code, CP0_Index, CP0_Wired, Wired_Write,
               EntryHi_VPN2, EntryHi_ASID, PageMask, EntryLo_G,
               Idx_VPN2_Out, Idx_Mask_Out, Idx_ASID_Out, Idx_G_Out,
               Hit_B, Index_B,
        output Op_Ready, Op_Done, Random,
               Idx_Index, Idx_Write, Idx_VPN2, Idx_Mask, Idx_ASID, Idx_G,
               VPN_B, ASID_B,
               Rd_VPN2, Rd_Mask, Rd_ASID, Rd_G, Probe_Miss, Probe_Index,
               dbg_state
    );

    modport master (
        output Op_Valid, Op_Code, CP0_Index, CP0_Wired, Wired_Write,
               EntryHi_VPN2, EntryHi_ASID, PageMask, EntryLo_G,
               Idx_VPN2_Out, Idx_Mask_Out, Idx_ASID_Out, Idx_G_Out,
               Hit_B, Index_B,
        input  Op_Ready, Op_Done, Random,
               Idx_Index, Idx_Write, Idx_VPN2, Idx_Mask, Idx_ASID, Idx_G,
               VPN_B, ASID_B,
               Rd_VPN2, Rd_Mask, Rd_ASID, Rd_G, Probe_Miss, Probe_Index,
               dbg_state
    );

endinterface

// File: rtl/tlb_random_ctr.sv
// CP0 Random register: counts down every cycle from LAST towards Wired and
// reloads LAST once it reaches Wired or when Wired is rewritten.
module tlb_random_ctr
    import tlb_pkg::*;
#(
    parameter logic [IDXW-1:0] LAST = IDXW'(ENTRIES - 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [IDXW-1:0] wired,
    input  logic            wired_write,
    output logic [IDXW-1:0] random
);

    // Free-running down-counter; never enters the wired region below CP0_Wired.
    always_ff @(posedge clock) begin
        if (reset) begin
            random <= LAST;
        end else if (wired_write) begin
            random <= LAST;
        end else if (random <= wired) begin
            random <= LAST;
        end else begin
            random <= random - IDXW'(1);
        end
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB instruction controller: sequences TLBR/TLBWI/TLBWR/TLBP against an
// external CAM with an index port and a lookup port, and holds the results.
module tlb_op_ctrl #(
    parameter int ENTRIES = tlb_pkg::ENTRIES
) (
    input  logic          clock,
    input  logic          reset,
    tlb_op_ctrl_if.slave  bus
);
    import tlb_pkg::*;

    state_t            state;
    logic              op_ready;
    logic              op_done;
    logic [IDXW-1:0]   random_q;
    logic [IDXW-1:0]   idx_index;
    logic              idx_write;
    logic [VPN2_W-1:0] idx_vpn2;
    logic [MASK_W-1:0] idx_mask;
    logic [ASID_W-1:0] idx_asid;
    logic              idx_g;
    logic [VPN2_W:0]   vpn_b;
    logic [ASID_W-1:0] asid_b;
    logic [VPN2_W-1:0] rd_vpn2;
    logic [MASK_W-1:0] rd_mask;
    logic [ASID_W-1:0] rd_asid;
    logic              rd_g;
    logic              probe_miss;
    logic [IDXW-1:0]   probe_index;

    tlb_random_ctr #(
        .LAST (IDXW'(ENTRIES - 1))
    ) u_random (
        .clock       (clock),
        .reset       (reset),
        .wired       (bus.CP0_Wired),
        .wired_write (bus.Wired_Write),
        .random      (random_q)
    );

    // Operation FSM; operands go straight into the CAM-facing output registers
    // on acceptance, so there is no separate operand latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            op_ready    <= 1'b1;
            op_done     <= 1'b0;
            idx_index   <= '0;
            idx_write   <= 1'b0;
            idx_vpn2    <= '0;
            idx_mask    <= '0;
            idx_asid    <= '0;
            idx_g       <= 1'b0;
            vpn_b       <= '0;
            asid_b      <= '0;
            rd_vpn2     <= '0;
            rd_mask     <= '0;
            rd_asid     <= '0;
            rd_g        <= 1'b0;
            probe_miss  <= 1'b0;
            probe_index <= '0;
        end else begin
            op_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.Op_Valid) begin
                        op_ready <= 1'b0;
                        case (bus.Op_Code)
                            OP_TLBR: begin
                                idx_index <= bus.CP0_Index;
                                state     <= ST_RD_ADDR;
                            end
                            OP_TLBWI, OP_TLBWR: begin
                                // TLBWR targets the Random value of the accept cycle
                                idx_index <= (bus.Op_Code == OP_TLBWR) ? random_q : bus.CP0_Index;
                                idx_vpn2  <= bus.EntryHi_VPN2;
                                idx_mask  <= bus.PageMask;
                                idx_asid  <= bus.EntryHi_ASID;
                                idx_g     <= bus.EntryLo_G;
                                idx_write <= 1'b1;
                                state     <= ST_WR;
                            end
                            OP_TLBP: begin
                                vpn_b  <= {bus.EntryHi_VPN2, 1'b0};
                                asid_b <= bus.EntryHi_ASID;
                                state  <= ST_PR_ADDR;
                            end
                            default: begin
                                state <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_RD_ADDR: begin
                    state <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    rd_vpn2  <= bus.Idx_VPN2_Out;
                    rd_mask  <= bus.Idx_Mask_Out;
                    rd_asid  <= bus.Idx_ASID_Out;
                    rd_g     <= bus.Idx_G_Out;
                    op_done  <= 1'b1;
                    op_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
                ST_WR: begin
                    idx_write <= 1'b0;
                    op_done   <= 1'b1;
                    op_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_PR_ADDR: begin
                    state <= ST_PR_CAP;
                end
                ST_PR_CAP: begin
                    probe_miss <= ~bus.Hit_B;
                    if (bus.Hit_B) begin
                        probe_index <= bus.Index_B;
                    end
                    op_done  <= 1'b1;
                    op_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    idx_write <= 1'b0;
                    op_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Drive the interface from the registered copies.
    assign bus.Op_Ready    = op_ready;
    assign bus.Op_Done     = op_done;
    assign bus.Random      = random_q;
    assign bus.Idx_Index   = idx_index;
    assign bus.Idx_Write   = idx_write;
    assign bus.Idx_VPN2    = idx_vpn2;
    assign bus.Idx_Mask    = idx_mask;
    assign bus.Idx_ASID    = idx_asid;
    assign bus.Idx_G       = idx_g;
    assign bus.VPN_B       = vpn_b;
    assign bus.ASID_B      = asid_b;
    assign bus.Rd_VPN2     = rd_vpn2;
    assign bus.Rd_Mask     = rd_mask;
    assign bus.Rd_ASID     = rd_asid;
    assign bus.Rd_G        = rd_g;
    assign bus.Probe_Miss  = probe_miss;
    assign bus.Probe_Index = probe_index;
    assign bus.dbg_state   = state;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a small behavioural CAM attached.
module tb_tlb_op_ctrl;
    import tlb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    tlb_op_ctrl_if bus ();

    tlb_op_ctrl #(.ENTRIES(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    logic [3:0] exp_q[$];

    // ---------------- behavioural CAM ----------------
    logic [18:0] cam_vpn2 [16];
    logic [15:0] cam_mask [16];
    logic [7:0]  cam_asid [16];
    logic        cam_g    [16];
    logic [15:0] cam_valid = '0;

    always @(posedge clock) begin
        if (bus.Idx_Write) begin
            cam_vpn2[bus.Idx_Index]  <= bus.Idx_VPN2 & ~{3'b000, bus.Idx_Mask};
            cam_mask[bus.Idx_Index]  <= bus.Idx_Mask;
            cam_asid[bus.Idx_Index]  <= bus.Idx_ASID;
            cam_g[bus.Idx_Index]     <= bus.Idx_G;
            cam_valid[bus.Idx_Index] <= 1'b1;
        end
    end

    always_comb begin
        bus.Idx_VPN2_Out = cam_vpn2[bus.Idx_Index];
        bus.Idx_Mask_Out = cam_mask[bus.Idx_Index];
        bus.Idx_ASID_Out = cam_asid[bus.Idx_Index];
        bus.Idx_G_Out    = cam_g[bus.Idx_Index];
    end

    always_comb begin
        bus.Hit_B   = 1'b0;
        bus.Index_B = '0;
        for (int i = 0; i < 16; i++) begin
            if (cam_valid[i] &&
                ((bus.VPN_B[19:1] & ~{3'b000, cam_mask[i]}) == cam_vpn2[i]) &&
                (cam_g[i] || (cam_asid[i] == bus.ASID_B))) begin
                bus.Hit_B   = 1'b1;
                bus.Index_B = 4'(i);
            end
        end
    end

    // ---------------- check / driver tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Presents a request in the current cycle and returns in the cycle after
    // acceptance with the operands scrambled, so late changes must be ignored.
    task automatic send_op(input logic [1:0] code, input logic [3:0] idx,
                           input logic [18:0] vpn2, input logic [15:0] mask,
                           input logic [7:0] asid, input logic g);
        bus.Op_Valid     = 1'b1;
        bus.Op_Code      = code;
        bus.CP0_Index    = idx;
        bus.EntryHi_VPN2 = vpn2;
        bus.PageMask     = mask;
        bus.EntryHi_ASID = asid;
        bus.EntryLo_G    = g;
        chk("ready_at_issue", 32'(bus.Op_Ready), 32'd1);
        @(negedge clock);
        bus.Op_Valid     = 1'b0;
        bus.CP0_Index    = ~idx;
        bus.EntryHi_VPN2 = ~vpn2;
        bus.PageMask     = ~mask;
        bus.EntryHi_ASID = ~asid;
        bus.EntryLo_G    = ~g;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        reset            = 1'b1;
        bus.Op_Valid     = 1'b0;
        bus.Op_Code      = 2'b00;
        bus.CP0_Index    = '0;
        bus.CP0_Wired    = '0;
        bus.Wired_Write  = 1'b0;
        bus.EntryHi_VPN2 = '0;
        bus.EntryHi_ASID = '0;
        bus.PageMask     = '0;
        bus.EntryLo_G    = 1'b0;

        repeat (2) @(negedge clock);
        chk("rst_ready",     32'(bus.Op_Ready),    32'd1);
        chk("rst_done",      32'(bus.Op_Done),     32'd0);
        chk("rst_idx_write", 32'(bus.Idx_Write),   32'd0);
        chk("rst_random",    32'(bus.Random),      32'd15);
        chk("rst_state",     32'(bus.dbg_state),   32'(ST_IDLE));
        chk("rst_rd_vpn2",   32'(bus.Rd_VPN2),     32'd0);
        chk("rst_probe_idx", 32'(bus.Probe_Index), 32'd0);
        chk("rst_vpn_b",     32'(bus.VPN_B),       32'd0);
        reset = 1'b0;

        // Random with Wired=0: 15 down to 0, then back to 15
        for (int i = 0; i <= 16; i++) exp_q.push_back(4'(15 - i));
        while (exp_q.size() > 0) begin
            chk("random_w0", 32'(bus.Random), 32'(exp_q.pop_front()));
            @(negedge clock);
        end

        // Wired write reloads 15, then wraps at 8
        bus.CP0_Wired   = 4'd8;
        bus.Wired_Write = 1'b1;
        @(negedge clock);
        chk("random_wired_write", 32'(bus.Random), 32'd15);
        bus.Wired_Write = 1'b0;
        for (int j = 1; j <= 8; j++) exp_q.push_back((j == 8) ? 4'd15 : 4'(15 - j));
        while (exp_q.size() > 0) begin
            @(negedge clock);
            chk("random_w8", 32'(bus.Random), 32'(exp_q.pop_front()));
        end

        // TLBWI index 3
        send_op(OP_TLBWI, 4'd3, 19'h16c6c, 16'h000f, 8'd200, 1'b0);
        chk("wi_state",     32'(bus.dbg_state), 32'(ST_WR));
        chk("wi_write",     32'(bus.Idx_Write), 32'd1);
        chk("wi_index",     32'(bus.Idx_Index), 32'd3);
        chk("wi_vpn2",      32'(bus.Idx_VPN2),  32'h16c6c);
        chk("wi_mask",      32'(bus.Idx_Mask),  32'h000f);
        chk("wi_asid",      32'(bus.Idx_ASID),  32'd200);
        chk("wi_g",         32'(bus.Idx_G),     32'd0);
        chk("wi_busy",      32'(bus.Op_Ready),  32'd0);
        chk("wi_done_n1",   32'(bus.Op_Done),   32'd0);
        @(negedge clock);
        chk("wi_done",      32'(bus.Op_Done),   32'd1);
        chk("wi_write_off", 32'(bus.Idx_Write), 32'd0);
        chk("wi_ready",     32'(bus.Op_Ready),  32'd1);

        // TLBR index 3, back to back; a request while busy must be dropped
        send_op(OP_TLBR, 4'd3, 19'h0, 16'h0, 8'd0, 1'b0);
        chk("rd_state1",  32'(bus.dbg_state), 32'(ST_RD_ADDR));
        chk("rd_index",   32'(bus.Idx_Index), 32'd3);
        chk("rd_done_n1", 32'(bus.Op_Done),   32'd0);
        bus.Op_Valid = 1'b1;
        bus.Op_Code  = OP_TLBWI;
        @(negedge clock);
        bus.Op_Valid = 1'b0;
        chk("rd_state2",   32'(bus.dbg_state), 32'(ST_RD_CAP));
        chk("rd_no_write", 32'(bus.Idx_Write), 32'd0);
        chk("rd_done_n2",  32'(bus.Op_Done),   32'd0);
        @(negedge clock);
        chk("rd_done",      32'(bus.Op_Done),   32'd1);
        chk("rd_vpn2",      32'(bus.Rd_VPN2),   32'h16c60);
        chk("rd_mask",      32'(bus.Rd_Mask),   32'h000f);
        chk("rd_asid",      32'(bus.Rd_ASID),   32'd200);
        chk("rd_g",         32'(bus.Rd_G),      32'd0);
        chk("rd_no_write3", 32'(bus.Idx_Write), 32'd0);

        // TLBP hit
        send_op(OP_TLBP, 4'd0, 19'h16c68, 16'h0, 8'd200, 1'b0);
        chk("pr_state", 32'(bus.dbg_state), 32'(ST_PR_ADDR));
        chk("pr_vpn_b", 32'(bus.VPN_B),     32'h2d8d0);
        chk("pr_asid",  32'(bus.ASID_B),    32'd200);
        @(negedge clock);
        chk("pr_done_n2", 32'(bus.Op_Done), 32'd0);
        @(negedge clock);
        chk("pr_done",     32'(bus.Op_Done),     32'd1);
        chk("pr_hit_miss", 32'(bus.Probe_Miss),  32'd0);
        chk("pr_hit_idx",  32'(bus.Probe_Index), 32'd3);

        // TLBP miss on ASID: index retained
        send_op(OP_TLBP, 4'd0, 19'h16c68, 16'h0, 8'd100, 1'b0);
        @(negedge clock);
        @(negedge clock);
        chk("pm_done",     32'(bus.Op_Done),     32'd1);
        chk("pm_miss",     32'(bus.Probe_Miss),  32'd1);
        chk("pm_idx_keep", 32'(bus.Probe_Index), 32'd3);
        chk("rd_hold",     32'(bus.Rd_VPN2),     32'h16c60);

        // TLBWI global entry 5 then TLBP back to back with another ASID
        send_op(OP_TLBWI, 4'd5, 19'h00abc, 16'h0, 8'd7, 1'b1);
        @(negedge clock);
        chk("wi5_done", 32'(bus.Op_Done), 32'd1);
        send_op(OP_TLBP, 4'd0, 19'h00abc, 16'h0, 8'd99, 1'b0);
        @(negedge clock);
        @(negedge clock);
        chk("pg_done", 32'(bus.Op_Done),     32'd1);
        chk("pg_miss", 32'(bus.Probe_Miss),  32'd0);
        chk("pg_idx",  32'(bus.Probe_Index), 32'd5);

        // TLBWR with Wired=4 at Random=9, then reset during the write cycle
        bus.CP0_Wired = 4'd4;
        k = 0;
        while (bus.Random !== 4'd9 && k < 40) begin
            @(negedge clock);
            k++;
        end
        chk("random_reaches_9", 32'(k < 40), 32'd1);
        send_op(OP_TLBWR, 4'd0, 19'h0f0f0, 16'h0, 8'd33, 1'b0);
        chk("wr_state", 32'(bus.dbg_state), 32'(ST_WR));
        chk("wr_write", 32'(bus.Idx_Write), 32'd1);
        chk("wr_index", 32'(bus.Idx_Index), 32'd9);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_done",   32'(bus.Op_Done),     32'd0);
        chk("abort_ready",  32'(bus.Op_Ready),    32'd1);
        chk("abort_write",  32'(bus.Idx_Write),   32'd0);
        chk("abort_state",  32'(bus.dbg_state),   32'(ST_IDLE));
        chk("abort_random", 32'(bus.Random),      32'd15);
        chk("abort_pidx",   32'(bus.Probe_Index), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_abort_done", 32'(bus.Op_Done), 32'd0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tlb_op_ctrl.md
TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 Parameter ENTRIES, default 16, meaning TLB entry count; index width IDXW = 4, fixed by ENTRIES=16.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Op_Valid  input  1  TLB instruction request.
REQ-005 Op_Code  input  2  00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP.
REQ-006 Op_Ready  output  1  high when a request can be accepted.
REQ-007 Op_Done  output  1  one-cycle completion pulse.
REQ-008 CP0_Index  input  4  entry index for TLBR/TLBWI.
REQ-009 CP0_Wired / Wired_Write  input  4 / 1  Wired value and its write strobe.
REQ-010 EntryHi_VPN2 / EntryHi_ASID / PageMask / EntryLo_G  input  19/8/16/1  write and probe operands.
REQ-011 Random  output  4  current CP0 Random value.
REQ-012 Idx_Index / Idx_Write  output  4/1  CAM index port address and write enable.
REQ-013 Idx_VPN2 / Idx_Mask / Idx_ASID / Idx_G  output  19/16/8/1  CAM write data.
REQ-014 Idx_VPN2_Out / Idx_Mask_Out / Idx_ASID_Out / Idx_G_Out  input  19/16/8/1  CAM read data.
REQ-015 VPN_B / ASID_B  output  20/8  CAM lookup port B request.
REQ-016 Hit_B / Index_B  input  1/4  CAM port B result, combinational from VPN_B/ASID_B.
REQ-017 Rd_VPN2 / Rd_Mask / Rd_ASID / Rd_G  output  19/16/8/1  TLBR result registers.
REQ-018 Probe_Miss / Probe_Index  output  1/4  TLBP result (Index.P and Index field).

Function
REQ-019 States IDLE, RD_ADDR, RD_CAP, WR, PR_ADDR, PR_CAP; Op_Ready = (state==IDLE).
REQ-020 Request accepted in cycle N when Op_Valid && Op_Ready; all operands latched at N, later changes ignored; Op_Valid while not ready is ignored (no queue).
REQ-021 TLBR: N+1 RD_ADDR drives Idx_Index=latched index; N+2 RD_CAP samples Idx_*_Out; N+3 IDLE, Op_Done=1, Rd_* hold captured values until next TLBR.
REQ-022 TLBWI/TLBWR: N+1 WR drives Idx_Index, Idx_* data and Idx_Write=1 for exactly one cycle; N+2 IDLE, Op_Done=1.
REQ-023 TLBWR index is the Random value in cycle N; TLBWI uses CP0_Index from cycle N.
REQ-024 TLBP: N+1 PR_ADDR drives VPN_B={VPN2,1'b0}, ASID_B; N+2 PR_CAP samples Hit_B/Index_B; N+3 Op_Done=1, Probe_Miss=~Hit_B, Probe_Index=Index_B on hit, previous value retained on miss.
REQ-025 New request accepted in the Op_Done cycle (back-to-back); TLBP following TLBWI observes the new entry.
REQ-026 Idx_Write is 0 in every state except WR; Idx_Index, VPN_B, ASID_B hold last driven value otherwise.
REQ-027 Random: each cycle, if Wired_Write then 15; else if Random <= CP0_Wired then 15; else Random-1; Wired=15 pins Random at 15.
REQ-028 Random decrements every cycle regardless of operation state.

Reset
REQ-029 Reset forces IDLE, Op_Ready=1, Op_Done=0, Idx_Write=0, Random=15; all other outputs 0.
REQ-030 Reset mid-operation aborts it: no Op_Done, Idx_Write low from the reset cycle's next edge, no result registers updated.

Structure
REQ-031 Shared package tlb_pkg holds ENTRIES, IDXW, field widths (19/16/8), Op_Code encodings, state encoding.
REQ-032 Random counter is a sub-module tlb_random_ctr; the remainder is a single FSM plus result registers.

Verification
REQ-033 Reset, Wired=0: Random reads 15,14,...,0,15 over 17 cycles; Wired_Write with Wired=8 -> Random=15, then wraps 8->15.
REQ-034 TLBWI index 3, VPN2=19'h16c6c, Mask=16'h000f, ASID=200 -> Idx_Write high exactly one cycle at N+1, Idx_Index=3, Op_Done at N+2.
REQ-035 TLBR index 3 after REQ-034 -> Op_Done at N+3, Rd_VPN2=19'h16c60, Rd_Mask=16'h000f, Rd_ASID=200, Rd_G=0.
REQ-036 TLBP VPN2=19'h16c68, ASID=200 -> Probe_Miss=0, Probe_Index=3; ASID=100 -> Probe_Miss=1, Probe_Index unchanged (3).
REQ-037 TLBWR issued with Wired=4 when Random=9 -> write to index 9; reset asserted in WR cycle -> no Op_Done, Op_Ready=1 next cycle.
